pc_sequencer: RTL and testbench

//  Next-generation program counter for the uC_8bits core: absolute jump, PC-relative

---
 rtl/pc_seq_pkg.sv | 17 +
 rtl/pc_sequencer_ret_stack.sv | 48 ++++
 rtl/pc_sequencer.sv | 120 ++++++++++++
 tb/tb_pc_sequencer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer: operation codes and their width.
package pc_seq_pkg;

    localparam int PC_OP_W = 3;

    typedef enum logic [PC_OP_W-1:0] {
        PC_HOLD = 3'b000,
        PC_INC  = 3'b001,
        PC_JMP  = 3'b010,
        PC_BR   = 3'b011,
        PC_CALL = 3'b100,
        PC_RET  = 3'b101,
        PC_TRAP = 3'b110,
        PC_RSVD = 3'b111
    } pc_op_t;

endpackage

// File: rtl/pc_sequencer_ret_stack.sv
// Hardware return-address LIFO. Push and pop are expected to be gated by the owner;
// a push while full or a pop while empty is silently ignored here.
module ret_stack #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           push_i,
    input  logic                           pop_i,
    input  logic [WIDTH-1:0]               push_data_i,
    output logic [WIDTH-1:0]               top_o,
    output logic [$clog2(DEPTH+1)-1:0]     count_o,
    output logic                           full_o,
    output logic                           empty_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [CW-1:0]    count_q;
    logic [IW-1:0]    wrIdx;
    logic [IW-1:0]    topIdx;

    assign wrIdx   = IW'(count_q);
    assign topIdx  = IW'(count_q - CW'(1));
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    // An empty stack reports zero rather than stale contents.
    assign top_o   = empty_o ? '0 : mem_q[topIdx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_i && !full_o) begin
            mem_q[wrIdx] <= push_data_i;
            count_q      <= count_q + CW'(1);
        end else if (pop_i && !empty_o) begin
            count_q <= count_q - CW'(1);
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter with jump, relative branch, CALL/RET via a hardware return stack and TRAP entry.
// Stack faults leave sticky flags and fall through to the next sequential address.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = 12,
    parameter int                    OFF_WIDTH    = 8,
    parameter int                    STACK_DEPTH  = 8,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [ADDR_WIDTH-1:0] TRAP_VECTOR  = 'h004
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               stall,
    input  logic [PC_OP_W-1:0]                 pc_op,
    input  logic [ADDR_WIDTH-1:0]              pc_target,
    input  logic [OFF_WIDTH-1:0]               pc_offset,
    input  logic                               err_clr,
    output logic [ADDR_WIDTH-1:0]              pc_out,
    output logic [ADDR_WIDTH-1:0]              ret_addr,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   sp,
    output logic                               stack_full,
    output logic                               stack_empty,
    output logic                               stk_ovf,
    output logic                               stk_unf
);

    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;
    logic [ADDR_WIDTH-1:0] pcPlusOne;
    logic [ADDR_WIDTH-1:0] brTarget;
    logic [ADDR_WIDTH-1:0] pushData;
    logic                  pushReq, popReq;
    logic                  ovfSet, unfSet;
    pc_op_t                op;

    assign op        = pc_op_t'(pc_op);
    assign pcPlusOne = pc_q + ADDR_WIDTH'(1);
    assign brTarget  = pc_q + ADDR_WIDTH'($signed(pc_offset));

    always_comb begin
        pc_d     = pc_q;
        pushReq  = 1'b0;
        popReq   = 1'b0;
        pushData = '0;
        ovfSet   = 1'b0;
        unfSet   = 1'b0;
        unique case (op)
            PC_INC:  pc_d = pcPlusOne;
            PC_JMP:  pc_d = pc_target;
            PC_BR:   pc_d = brTarget;
            PC_CALL: begin
                if (stack_full) begin
                    pc_d   = pcPlusOne;
                    ovfSet = 1'b1;
                end else begin
                    pushReq  = 1'b1;
                    pushData = pcPlusOne;
                    pc_d     = pc_target;
                end
            end
            PC_RET: begin
                if (stack_empty) begin
                    pc_d   = pcPlusOne;
                    unfSet = 1'b1;
                end else begin
                    popReq = 1'b1;
                    pc_d   = ret_addr;
                end
            end
            // The trapping instruction's own address is saved so it re-executes on return.
            PC_TRAP: begin
                if (stack_full) begin
                    pc_d   = pcPlusOne;
                    ovfSet = 1'b1;
                end else begin
                    pushReq  = 1'b1;
                    pushData = pc_q;
                    pc_d     = TRAP_VECTOR;
                end
            end
            default: pc_d = pc_q;
        endcase
        ovf_d = ovfSet | (ovf_q & ~err_clr);
        unf_d = unfSet | (unf_q & ~err_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q  <= RESET_VECTOR;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else if (!stall) begin
            pc_q  <= pc_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    ret_stack #(
        .WIDTH (ADDR_WIDTH),
        .DEPTH (STACK_DEPTH)
    ) u_ret_stack (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (pushReq & ~stall),
        .pop_i       (popReq & ~stall),
        .push_data_i (pushData),
        .top_o       (ret_addr),
        .count_o     (sp),
        .full_o      (stack_full),
        .empty_o     (stack_empty)
    );

    assign pc_out  = pc_q;
    assign stk_ovf = ovf_q;
    assign stk_unf = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed vector table, hand-written stack corner
// sequences and randomized traffic compared against a queue-based reference model.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic [2:0]  pc_op;
    logic [11:0] pc_target;
    logic [7:0]  pc_offset;
    logic        err_clr;
    logic [11:0] pc_out;
    logic [11:0] ret_addr;
    logic [3:0]  sp;
    logic        stack_full;
    logic        stack_empty;
    logic        stk_ovf;
    logic        stk_unf;

    int passCount = 0;
    int checkCount = 0;

    // Reference model state: architectural PC, return stack as a queue, sticky flags.
    int          mPc;
    logic [11:0] mStack[$];
    bit          mOvf;
    bit          mUnf;

    pc_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .pc_op       (pc_op),
        .pc_target   (pc_target),
        .pc_offset   (pc_offset),
        .err_clr     (err_clr),
        .pc_out      (pc_out),
        .ret_addr    (ret_addr),
        .sp          (sp),
        .stack_full  (stack_full),
        .stack_empty (stack_empty),
        .stk_ovf     (stk_ovf),
        .stk_unf     (stk_unf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [11:0] tgt;
        logic [7:0]  off;
        bit          stl;
        bit          clr;
        logic [11:0] ePc;
        int          eSp;
        logic [11:0] eRet;
        bit          eOvf;
        bit          eUnf;
    } vec_t;

    vec_t vecs[$];

    function automatic void modelReset();
        mPc = 0;
        mStack.delete();
        mOvf = 0;
        mUnf = 0;
    endfunction

    function automatic void modelStep(input logic [2:0] op, input logic [11:0] tgt,
                                      input logic [7:0] off, input bit stl, input bit clr);
        bit fo = 0;
        bit fu = 0;
        if (stl) return;
        case (op)
            3'd1: mPc = (mPc + 1) % 4096;
            3'd2: mPc = int'(tgt);
            3'd3: mPc = (mPc + int'($signed(off))) & 4095;
            3'd4: begin
                if (mStack.size() == 8) begin
                    fo = 1; mPc = (mPc + 1) % 4096;
                end else begin
                    mStack.push_back(12'((mPc + 1) % 4096)); mPc = int'(tgt);
                end
            end
            3'd5: begin
                if (mStack.size() == 0) begin
                    fu = 1; mPc = (mPc + 1) % 4096;
                end else begin
                    mPc = int'(mStack.pop_back());
                end
            end
            3'd6: begin
                if (mStack.size() == 8) begin
                    fo = 1; mPc = (mPc + 1) % 4096;
                end else begin
                    mStack.push_back(12'(mPc)); mPc = 4;
                end
            end
            default: ;
        endcase
        mOvf = fo | (mOvf & !clr);
        mUnf = fu | (mUnf & !clr);
    endfunction

    task automatic applyStimulus(input logic [2:0] op, input logic [11:0] tgt,
                                 input logic [7:0] off, input bit stl, input bit clr);
        pc_op     = op;
        pc_target = tgt;
        pc_offset = off;
        stall     = stl;
        err_clr   = clr;
        modelStep(op, tgt, off, stl, clr);
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [11:0] ePc, input int eSp,
                               input logic [11:0] eRet, input bit eOvf, input bit eUnf);
        logic [3:0] eFlags;
        eFlags = {eSp == 8, eSp == 0, eOvf, eUnf};
        checkCount++;
        if (pc_out === ePc) passCount++;
        else $display("[TB] FAIL %s pc_out: got %h expected %h", name, pc_out, ePc);
        checkCount++;
        if (sp === 4'(eSp)) passCount++;
        else $display("[TB] FAIL %s sp: got %0d expected %0d", name, sp, eSp);
        checkCount++;
        if (ret_addr === eRet) passCount++;
        else $display("[TB] FAIL %s ret_addr: got %h expected %h", name, ret_addr, eRet);
        checkCount++;
        if ({stack_full, stack_empty, stk_ovf, stk_unf} === eFlags) passCount++;
        else $display("[TB] FAIL %s full/empty/ovf/unf: got %b expected %b", name,
                      {stack_full, stack_empty, stk_ovf, stk_unf}, eFlags);
    endtask

    task automatic checkModel(input string name);
        checkOutput(name, 12'(mPc), mStack.size(),
                    (mStack.size() == 0) ? 12'h000 : mStack[$], mOvf, mUnf);
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        modelReset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic void addVec(input logic [2:0] op, input logic [11:0] tgt,
                                   input logic [7:0] off, input bit stl, input bit clr,
                                   input logic [11:0] ePc, input int eSp,
                                   input logic [11:0] eRet, input bit eOvf, input bit eUnf);
        vecs.push_back('{op, tgt, off, stl, clr, ePc, eSp, eRet, eOvf, eUnf});
    endfunction

    initial begin
        rst_n = 1'b0; stall = 1'b0; pc_op = 3'd0;
        pc_target = '0; pc_offset = '0; err_clr = 1'b0;

        //      op    tgt     off    stl clr  pc     sp ret     ovf unf
        addVec(3'd2, 12'hFFE, 8'h00, 0, 0, 12'hFFE, 0, 12'h000, 0, 0);
        addVec(3'd1, 12'h000, 8'h00, 0, 0, 12'hFFF, 0, 12'h000, 0, 0);
        addVec(3'd1, 12'h000, 8'h00, 0, 0, 12'h000, 0, 12'h000, 0, 0);
        addVec(3'd2, 12'h001, 8'h00, 0, 0, 12'h001, 0, 12'h000, 0, 0);
        addVec(3'd3, 12'h000, 8'hFD, 0, 0, 12'hFFE, 0, 12'h000, 0, 0);
        addVec(3'd3, 12'h000, 8'h05, 0, 0, 12'h003, 0, 12'h000, 0, 0);
        addVec(3'd2, 12'h020, 8'h00, 0, 0, 12'h020, 0, 12'h000, 0, 0);
        addVec(3'd4, 12'h100, 8'h00, 0, 0, 12'h100, 1, 12'h021, 0, 0);
        addVec(3'd4, 12'h200, 8'h00, 0, 0, 12'h200, 2, 12'h101, 0, 0);
        addVec(3'd5, 12'h000, 8'h00, 0, 0, 12'h101, 1, 12'h021, 0, 0);
        addVec(3'd5, 12'h000, 8'h00, 0, 0, 12'h021, 0, 12'h000, 0, 0);
        addVec(3'd2, 12'h050, 8'h00, 0, 0, 12'h050, 0, 12'h000, 0, 0);
        addVec(3'd5, 12'h000, 8'h00, 0, 0, 12'h051, 0, 12'h000, 0, 1);
        addVec(3'd0, 12'h000, 8'h00, 0, 1, 12'h051, 0, 12'h000, 0, 0);
        addVec(3'd2, 12'h040, 8'h00, 0, 0, 12'h040, 0, 12'h000, 0, 0);
        addVec(3'd6, 12'h000, 8'h00, 0, 0, 12'h004, 1, 12'h040, 0, 0);
        addVec(3'd5, 12'h000, 8'h00, 0, 0, 12'h040, 0, 12'h000, 0, 0);
        addVec(3'd4, 12'h300, 8'h00, 1, 0, 12'h040, 0, 12'h000, 0, 0);
        addVec(3'd2, 12'h123, 8'h00, 1, 0, 12'h040, 0, 12'h000, 0, 0);
        addVec(3'd4, 12'h300, 8'h00, 1, 0, 12'h040, 0, 12'h000, 0, 0);
        addVec(3'd4, 12'h300, 8'h00, 0, 0, 12'h300, 1, 12'h041, 0, 0);
        addVec(3'd7, 12'h555, 8'h00, 0, 0, 12'h300, 1, 12'h041, 0, 0);
        addVec(3'd5, 12'h000, 8'h00, 0, 0, 12'h041, 0, 12'h000, 0, 0);
        addVec(3'd5, 12'h000, 8'h00, 0, 1, 12'h042, 0, 12'h000, 0, 1);
        addVec(3'd0, 12'h000, 8'h00, 1, 1, 12'h042, 0, 12'h000, 0, 1);
        addVec(3'd0, 12'h000, 8'h00, 0, 1, 12'h042, 0, 12'h000, 0, 0);

        #2;
        checkOutput("reset", 12'h000, 0, 12'h000, 0, 0);
        doReset();
        checkOutput("after_reset", 12'h000, 0, 12'h000, 0, 0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].op, vecs[i].tgt, vecs[i].off, vecs[i].stl, vecs[i].clr);
            checkOutput($sformatf("vec%0d", i), vecs[i].ePc, vecs[i].eSp, vecs[i].eRet,
                        vecs[i].eOvf, vecs[i].eUnf);
        end

        // Fill the stack to depth, then overflow via CALL and TRAP.
        doReset();
        applyStimulus(3'd2, 12'h010, 8'h00, 0, 0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(3'd4, 12'(12'h100 + i), 8'h00, 0, 0);
        end
        checkOutput("stack_filled", 12'h107, 8, 12'h107, 0, 0);
        applyStimulus(3'd2, 12'h300, 8'h00, 0, 0);
        applyStimulus(3'd4, 12'h3FF, 8'h00, 0, 0);
        checkOutput("call_overflow", 12'h301, 8, 12'h107, 1, 0);
        applyStimulus(3'd6, 12'h000, 8'h00, 0, 0);
        checkOutput("trap_overflow", 12'h302, 8, 12'h107, 1, 0);
        applyStimulus(3'd0, 12'h000, 8'h00, 0, 1);
        checkOutput("ovf_clear", 12'h302, 8, 12'h107, 0, 0);
        applyStimulus(3'd5, 12'h000, 8'h00, 0, 0);
        checkOutput("pop_from_full", 12'h107, 7, 12'h106, 0, 0);
        applyStimulus(3'd4, 12'h3FF, 8'h00, 0, 0);
        applyStimulus(3'd4, 12'h3FF, 8'h00, 0, 0);
        checkOutput("refill_overflow", 12'h400, 8, 12'h108, 1, 0);

        // Asynchronous reset between clock edges with a full stack and a set flag.
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", 12'h000, 0, 12'h000, 0, 0);
        modelReset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(3'd5, 12'h000, 8'h00, 0, 0);
        checkOutput("ret_after_reset", 12'h001, 0, 12'h000, 0, 1);

        for (int n = 0; n < 400; n++) begin
            logic [2:0] rop;
            rop = 3'($urandom_range(0, 7));
            // Bias toward CALL so the stack reaches full regularly.
            if ($urandom_range(0, 3) == 0) rop = 3'd4;
            applyStimulus(rop, 12'($urandom), 8'($urandom),
                          $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0);
            checkModel($sformatf("rand%0d", n));
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
